pu_mv_sequencer: RTL

Sequencer for the matrix-vector PU. It accepts one command holding a vector base address and a matrix base address, then streams MATRIX_COL vector elements and matrix columns from two synchronous-read memories into the PU with START asserted. It waits for PU DONE, captures the PU result, and presents it to the host with a valid/ready handshake. A DONE timeout aborts the operation with a one-cycle error pulse.

---
 rtl/pu_mv_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/pu_mv_sequencer.sv
// Matrix-vector PU sequencer: streams vector/matrix operands
// into the PU, waits for DONE and returns the captured result.
module pu_mv_sequencer #(
  parameter int WIDTH_OP1  = 16,
  parameter int WIDTH_OP2  = 16,
  parameter int WIDTH_OUT  = 32,
  parameter int MATRIX_ROW = 8,
  parameter int MATRIX_COL = 16,
  parameter int ADDR_W     = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                            CLK,
  input  logic                            RSTN,
  input  logic                            CMD_VALID,
  output logic                            CMD_READY,
  input  logic [ADDR_W-1:0]               CMD_VEC_BASE,
  input  logic [ADDR_W-1:0]               CMD_MAT_BASE,
  output logic                            VEC_RD_EN,
  output logic [ADDR_W-1:0]               VEC_RD_ADDR,
  input  logic [WIDTH_OP1-1:0]            VEC_RD_DATA,
  output logic                            MAT_RD_EN,
  output logic [ADDR_W-1:0]               MAT_RD_ADDR,
  input  logic [WIDTH_OP2*MATRIX_ROW-1:0] MAT_RD_DATA,
  output logic [WIDTH_OP1-1:0]            PU_A,
  output logic [WIDTH_OP2*MATRIX_ROW-1:0] PU_B,
  output logic                            PU_START,
  input  logic                            PU_DONE,
  input  logic [WIDTH_OUT*MATRIX_ROW-1:0] PU_OUT,
  output logic                            RSLT_VALID,
  input  logic                            RSLT_READY,
  output logic [WIDTH_OUT*MATRIX_ROW-1:0] RSLT_DATA,
  output logic                            BUSY,
  output logic                            ERR
);

  localparam int KW = (MATRIX_COL > 1) ? $clog2(MATRIX_COL) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int OW = WIDTH_OUT * MATRIX_ROW;

  localparam logic [KW-1:0] KLAST = KW'(MATRIX_COL - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   vbase_q, vbase_d;
  logic [ADDR_W-1:0]   mbase_q, mbase_d;
  logic [KW-1:0]       k_q, k_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [OW-1:0]       rslt_q, rslt_d;

  logic [ADDR_W-1:0]   nxt_off;
  logic                k_last;
  logic                tmo_hit;

  // offset of the read issued during STREAM (element k+1)
  assign nxt_off = ADDR_W'(k_q) + ADDR_W'(1);
  assign k_last  = (k_q == KLAST);
  assign tmo_hit = (tmo_q == TLAST);

  // state and datapath registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      vbase_q <= '0;
      mbase_q <= '0;
      k_q     <= '0;
      tmo_q   <= '0;
      rslt_q  <= '0;
    end else begin
      state_q <= state_d;
      vbase_q <= vbase_d;
      mbase_q <= mbase_d;
      k_q     <= k_d;
      tmo_q   <= tmo_d;
      rslt_q  <= rslt_d;
    end
  end

  // next state, counters, command latch and result capture
  always_comb begin
    state_d = state_q;
    vbase_d = vbase_q;
    mbase_d = mbase_q;
    k_d     = k_q;
    tmo_d   = tmo_q;
    rslt_d  = rslt_q;
    unique case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          vbase_d = CMD_VEC_BASE;
          mbase_d = CMD_MAT_BASE;
          k_d     = '0;
          tmo_d   = '0;
          state_d = S_PRIME;
        end
      end
      S_PRIME: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (k_last) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // DONE takes priority over an expiring timeout
        if (PU_DONE) begin
          rslt_d  = PU_OUT;
          tmo_d   = '0;
          state_d = S_RESULT;
        end else if (tmo_hit) begin
          tmo_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_RESULT: begin
        if (RSLT_READY) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // outputs decoded from the current state
  always_comb begin
    CMD_READY   = 1'b0;
    BUSY        = 1'b1;
    VEC_RD_EN   = 1'b0;
    VEC_RD_ADDR = '0;
    MAT_RD_EN   = 1'b0;
    MAT_RD_ADDR = '0;
    PU_A        = '0;
    PU_B        = '0;
    PU_START    = 1'b0;
    RSLT_VALID  = 1'b0;
    ERR         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        CMD_READY = 1'b1;
        BUSY      = 1'b0;
      end
      S_PRIME: begin
        VEC_RD_EN   = 1'b1;
        VEC_RD_ADDR = vbase_q;
        MAT_RD_EN   = 1'b1;
        MAT_RD_ADDR = mbase_q;
      end
      S_STREAM: begin
        PU_START = 1'b1;
        PU_A     = VEC_RD_DATA;
        PU_B     = MAT_RD_DATA;
        if (!k_last) begin
          VEC_RD_EN   = 1'b1;
          VEC_RD_ADDR = vbase_q + nxt_off;
          MAT_RD_EN   = 1'b1;
          MAT_RD_ADDR = mbase_q + nxt_off;
        end
      end
      S_WAIT: begin
        ERR = tmo_hit && !PU_DONE;
      end
      S_RESULT: begin
        RSLT_VALID = 1'b1;
      end
      default: begin
        BUSY = 1'b1;
      end
    endcase
  end

  assign RSLT_DATA = rslt_q;

endmodule
